// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants, WB control indices and miss FSM encoding
package mips_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } miss_state_e;

endpackage

// File: rtl/mem_miss_ctr.sv
// rtl/mem_miss_ctr.sv - cache-miss wait FSM with saturating miss counter and sticky timeout
module mem_miss_ctr
  import mips_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int MISS_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             data_hit,
  input  logic             flush,
  output logic [CNT_W-1:0] miss_cycles,
  output logic             miss_timeout
);

  miss_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (flush) begin
      state_d   = RUN;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (in_valid && !data_hit) begin
            state_d = MISS;
            cnt_d   = CNT_W'(1);
          end
        end
        MISS: begin
          if (data_hit || !in_valid) begin
            state_d = RUN;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
      // Sticky: once the count reaches the threshold only flush/reset clears it.
      if (cnt_d == CNT_W'(MISS_TIMEOUT)) timeout_d = 1'b1;
    end
  end

  assign miss_cycles  = cnt_q;
  assign miss_timeout = timeout_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with handshake, miss stall, flush and WB data select
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int CTRL_W       = 2,
  parameter int MISS_TIMEOUT = 15,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  data_hit,
  input  logic                  flush,
  input  logic [CTRL_W-1:0]     control_wb_in,
  input  logic [DATA_W-1:0]     read_data_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     control_wb_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic [DATA_W-1:0]     wb_data_out,
  output logic                  reg_write,
  output logic                  stall_out,
  output logic [CNT_W-1:0]      miss_cycles,
  output logic                  miss_timeout
);

  logic                  valid_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     alu_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic                  capture;
  logic                  drain;

  assign in_ready = data_hit & (~valid_q | out_ready) & ~flush;
  assign capture  = in_valid & in_ready;
  assign drain    = valid_q & out_ready;

  // Drain and capture in the same cycle simply overwrite the entry: full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      ctrl_q  <= control_wb_in;
      rdata_q <= read_data_in;
      alu_q   <= alu_result_in;
      wreg_q  <= write_reg_in;
    end else if (drain) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign out_valid      = valid_q;
  assign control_wb_out = valid_q ? ctrl_q : '0;
  assign read_data_out  = rdata_q;
  assign alu_result_out = alu_q;
  assign write_reg_out  = wreg_q;
  assign wb_data_out    = control_wb_out[WB_MEMTOREG] ? rdata_q : alu_q;
  assign reg_write      = valid_q & control_wb_out[WB_REGWRITE] & out_ready;
  assign stall_out      = in_valid & ~in_ready & ~flush;

  mem_miss_ctr #(
    .CNT_W       (CNT_W),
    .MISS_TIMEOUT(MISS_TIMEOUT)
  ) u_miss_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .data_hit    (data_hit),
    .flush       (flush),
    .miss_cycles (miss_cycles),
    .miss_timeout(miss_timeout)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        data_hit;
  logic        flush;
  logic [1:0]  control_wb_in;
  logic [31:0] read_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  write_reg_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  control_wb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  write_reg_out;
  logic [31:0] wb_data_out;
  logic        reg_write;
  logic        stall_out;
  logic [7:0]  miss_cycles;
  logic        miss_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_W(32), .REG_ADDR_W(5), .CTRL_W(2), .MISS_TIMEOUT(15), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_hit      (data_hit),
    .flush         (flush),
    .control_wb_in (control_wb_in),
    .read_data_in  (read_data_in),
    .alu_result_in (alu_result_in),
    .write_reg_in  (write_reg_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .control_wb_out(control_wb_out),
    .read_data_out (read_data_out),
    .alu_result_out(alu_result_out),
    .write_reg_out (write_reg_out),
    .wb_data_out   (wb_data_out),
    .reg_write     (reg_write),
    .stall_out     (stall_out),
    .miss_cycles   (miss_cycles),
    .miss_timeout  (miss_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are settled 1 ns after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic hit, input logic [1:0] c,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
    in_valid      = v;
    data_hit      = hit;
    control_wb_in = c;
    read_data_in  = rd;
    alu_result_in = alu;
    write_reg_in  = wr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 5'd0);
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_ctrl", control_wb_out, 0);
    check("rst_wb_data", wb_data_out, 0);
    check("rst_miss_cycles", miss_cycles, 0);
    check("rst_timeout", miss_timeout, 0);
    #2 rst_n = 1'b1;
    tick();

    // Basic capture, MemtoReg=1 then MemtoReg=0 back to back
    drive(1'b1, 1'b1, 2'b11, 32'd2, 32'd7, 5'd5);
    #1;
    check("cap_in_ready", in_ready, 1);
    check("cap_stall", stall_out, 0);
    tick();
    check("cap_out_valid", out_valid, 1);
    check("cap_wb_data_mem", wb_data_out, 2);
    check("cap_reg_write", reg_write, 1);
    check("cap_write_reg", write_reg_out, 5);
    drive(1'b1, 1'b1, 2'b10, 32'd2, 32'd7, 5'd5);
    tick();
    check("cap_wb_data_alu", wb_data_out, 7);
    check("cap_ctrl_10", control_wb_out, 2'b10);
    drive(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    check("drain_out_valid", out_valid, 0);
    check("drain_ctrl", control_wb_out, 0);
    check("drain_reg_write", reg_write, 0);

    // Four-cycle miss
    drive(1'b1, 1'b0, 2'b11, 32'h11, 32'h22, 5'd9);
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("miss_in_ready", in_ready, 0);
      check("miss_stall", stall_out, 1);
      tick();
      check("miss_cycles_cnt", miss_cycles, i);
      check("miss_out_valid", out_valid, 0);
    end
    data_hit = 1'b1;
    #1;
    check("miss_end_in_ready", in_ready, 1);
    tick();
    check("miss_end_cnt", miss_cycles, 0);
    check("miss_end_out_valid", out_valid, 1);
    check("miss_end_rdata", read_data_out, 32'h11);
    drive(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();

    // Sixteen-cycle miss crossing the timeout threshold
    drive(1'b1, 1'b0, 2'b11, 32'h33, 32'h44, 5'd10);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("to_cnt", miss_cycles, k);
      check("to_flag", miss_timeout, (k >= 15) ? 1 : 0);
    end
    data_hit = 1'b1;
    tick();
    check("to_after_hit_cnt", miss_cycles, 0);
    check("to_after_hit_flag", miss_timeout, 1);
    check("to_after_hit_valid", out_valid, 1);
    drive(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    check("to_sticky", miss_timeout, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("to_flush_clear", miss_timeout, 0);

    // Backpressure then drain+capture in one cycle
    drive(1'b1, 1'b1, 2'b11, 32'hA1, 32'hA2, 5'd3);
    tick();
    check("bp_a_valid", out_valid, 1);
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 32'hB1, 32'hB2, 5'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_stall", stall_out, 1);
      tick();
      check("bp_hold_wr", write_reg_out, 3);
      check("bp_hold_rd", read_data_out, 32'hA1);
      check("bp_hold_valid", out_valid, 1);
      check("bp_reg_write", reg_write, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_reg_write", reg_write, 1);
    tick();
    check("bp_new_valid", out_valid, 1);
    check("bp_new_wr", write_reg_out, 4);
    check("bp_new_wb_data", wb_data_out, 32'hB2);

    // Flush against a valid incoming instruction
    drive(1'b1, 1'b1, 2'b11, 32'hC1, 32'hC2, 5'd7);
    flush = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    check("fl_stall", stall_out, 0);
    tick();
    flush = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_ctrl", control_wb_out, 0);
    check("fl_reg_write", reg_write, 0);

    // Asynchronous reset in the middle of a miss
    drive(1'b1, 1'b1, 2'b11, 32'hD1, 32'hD2, 5'd8);
    tick();
    out_ready = 1'b0;
    data_hit  = 1'b0;
    tick();
    tick();
    check("ar_pre_cnt", miss_cycles, 2);
    check("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_ctrl", control_wb_out, 0);
    check("ar_alu", alu_result_out, 0);
    check("ar_wr", write_reg_out, 0);
    check("ar_cnt", miss_cycles, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3 rst_n = 1'b1;
    tick();
    check("ar_rel_cnt", miss_cycles, 0);
    check("ar_rel_valid", out_valid, 0);
    in_valid = 1'b1;
    tick();
    check("ar_new_miss_cnt", miss_cycles, 1);
    in_valid = 1'b0;
    tick();
    check("ar_idle_cnt", miss_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
